div_seq: RTL and testbench
==========================

// Module: div_seq
// PURPOSE
//  Multi-cycle restoring divider for DIV/IDIV; fills the division path that the combinational ALU stubs to zero.
//  Sits beside the ALU in the execute stage: same x/y operands in, {remainder,quotient} out on the mul/div result path (t=3).
//  Raises a divide-error request that the sequencer turns into INT 0.
// PARAMETERS
//  XW  32  dividend width; fixed at 2*YW
//  YW  16  divisor width; only 16 supported
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  start      in   1   request; sampled only in IDLE
//  x          in   32  dividend: word = DX:AX, byte = x[15:0] (AX)
//  y          in   16  divisor: word = y, byte = y[7:0]
//  word_op    in   1   1 = 32/16 division, 0 = 16/8 division
//  signed_op  in   1   1 = IDIV, 0 = DIV
//  busy       out  1   operation in flight
//  done       out  1   one-cycle pulse; out/exc valid
//  exc        out  1   divide error (zero divisor or quotient overflow); valid with done
//  out        out  32  word {rem16,quo16}; byte {16'd0,rem8,quo8}
// BEHAVIOUR
//  - Reset: state IDLE; busy=0, done=0, exc=0, out=0; acts immediately, including mid-operation.
//  - States: IDLE, RUN, FIX.
//  - IDLE edge with start=1 latches word_op, signed_op, |x| and |y| (two's-complement magnitudes when signed_op), and the operand signs.
//  - From IDLE: divisor==0 goes to FIX with a zero flag set; otherwise goes to RUN with the iteration count N = 16 (word) or 8 (byte).
//  - RUN: one restoring step per clock; shift the partial remainder left, bring in the next dividend bit, trial-subtract |y|, shift in the quotient bit.
//  - After N edges in RUN, go to FIX.
//  - FIX (one edge): negate quotient if the operand signs differ; remainder takes the dividend's sign (truncate toward zero); evaluate overflow.
//  - Overflow, unsigned: the magnitude quotient does not fit in 16 (word) or 8 (byte) bits.
//  - Overflow, signed: quotient outside -2^15..2^15-1 (word) or -2^7..2^7-1 (byte).
//  - The internal quotient register is one bit wider than the result so overflow is exact.
//  - FIX -> IDLE with done=1 for one cycle:
//      exc=0: out updated.
//      exc=1: out holds its previous value.
//  - Latency from the start edge to the done cycle:
//      word: 17 edges; byte: 9 edges; zero divisor: 2 edges.
//  - busy=1 from the cycle after the start edge through the FIX cycle; busy=0 while done=1.
//  - start while busy is ignored, not queued. start in the done cycle is accepted (IDLE).
//  - Byte mode: upper 16 bits of out are zero; x[31:16] and y[15:8] are ignored.
//  - out and exc hold until the next completed operation.
// CONFIGURATION
//  DIV_RADIX4_EN defined:
//    - RUN retires 2 quotient bits per clock (two chained trial subtractions).
//    - N = 8 (word) / 4 (byte); latency is 9 / 5 edges; zero divisor is still 2.
//    - Results and exc are identical to radix-2.
//  DIV_RADIX4_EN undefined:
//    - Radix-2 as described above.
// TESTING
//  1. DIV word x=32'h0001_0000 y=16'h0003 -> out=32'h0001_5555, exc=0, done at edge 17 (9 with DIV_RADIX4_EN).
//  2. IDIV byte x=16'hFF9C (-100) y=8'h07 -> out=32'h0000_FEF2 (q=-14, r=-2), exc=0, done at edge 9.
//  3. DIV word y=0, any x -> exc=1, done at edge 2, out unchanged from prior result.
//  4. DIV word x=32'h0002_0000 y=16'h0001 -> exc=1. DIV byte x=16'h00FF y=8'h01 -> out=32'h0000_00FF, exc=0.
//  5. IDIV word x=32'hFFFF_8000 y=16'h0001 -> out=32'h0000_8000, exc=0; same x with y=16'hFFFF -> exc=1.
//  6. Assert rst at RUN edge 5, then start again -> busy=0/done=0 immediately after reset; the new op completes normally.
//     Pulse start mid-RUN -> ignored; exactly one done.

Source files
------------

// File: rtl/div_seq_if.sv
// Divider request/result bundle: operands and mode in, status and packed result out.
// Reg-to-reg boundary, no timing of its own; a request is accepted only while busy is low.
// Requests made while busy are dropped by the slave; there is no flow control toward the master.
interface div_seq_if;
    logic        start;
    logic [31:0] x;
    logic [15:0] y;
    logic        word_op;
    logic        signed_op;
    logic        busy;
    logic        done;
    logic        exc;
    logic [31:0] out;

    modport master (
        output start, x, y, word_op, signed_op,
        input  busy, done, exc, out
    );

    modport slave (
        input  start, x, y, word_op, signed_op,
        output busy, done, exc, out
    );
endinterface

// File: rtl/div_seq.sv
// Sequential restoring divider for DIV/IDIV (32/16 word, 16/8 byte), {rem,quo} result plus divide-error flag.
// Latency start-to-done: word 17, byte 9, zero divisor 2 (DIV_RADIX4_EN: word 9, byte 5).
// No queueing: start is sampled only while idle; results hold until the next completed operation.
module div_seq #(
    parameter int XW = 32,
    parameter int YW = 16
) (
    input  logic      clk,
    input  logic      rst,
    div_seq_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

`ifdef DIV_RADIX4_EN
    localparam logic [3:0] RUN_W = 4'd7;
    localparam logic [3:0] RUN_B = 4'd3;
`else
    localparam logic [3:0] RUN_W = 4'd15;
    localparam logic [3:0] RUN_B = 4'd7;
`endif

    // One restoring step on {partial remainder, dividend/quotient shift register}.
    function automatic logic [2*YW-1:0] rstep(input logic [YW-1:0] r, input logic [YW-1:0] q,
                                              input logic [YW-1:0] d);
        logic [YW:0] t;
        logic [YW:0] diff;
        t    = {r, q[YW-1]};
        diff = t - {1'b0, d};
        if (t >= {1'b0, d})
            rstep = {diff[YW-1:0], q[YW-2:0], 1'b1};
        else
            rstep = {t[YW-1:0], q[YW-2:0], 1'b0};
    endfunction

    function automatic logic [2*YW-1:0] iter(input logic [YW-1:0] r, input logic [YW-1:0] q,
                                             input logic [YW-1:0] d);
`ifdef DIV_RADIX4_EN
        logic [2*YW-1:0] s;
        s    = rstep(r, q, d);
        iter = rstep(s[2*YW-1:YW], s[YW-1:0], d);
`else
        iter = rstep(r, q, d);
`endif
    endfunction

    state_t          state_q, state_d;
    logic            load, step, fix;
    logic [YW-1:0]   rem_q, dq_q, d_q;
    logic [3:0]      cnt_q;
    logic            word_q, signed_q, sx_q, sy_q, ovf_q, zero_q;
    logic            done_q, exc_q;
    logic [XW-1:0]   out_q;

    logic            sx, sy;
    logic [XW-1:0]   x_mag;
    logic [YW-1:0]   y_mag, hi0, dq0, x_lo_neg;
    logic [7:0]      y_lo_neg;
    logic [2*YW-1:0] first_s, run_s;

    // Byte operands are aligned so the quotient lands in dq[7:0] and the remainder in rem[7:0].
    always_comb begin
        x_lo_neg = -bus.x[YW-1:0];
        y_lo_neg = -bus.y[7:0];
        if (bus.word_op) begin
            sx    = bus.signed_op & bus.x[XW-1];
            sy    = bus.signed_op & bus.y[YW-1];
            x_mag = sx ? -bus.x : bus.x;
            y_mag = sy ? -bus.y : bus.y;
            hi0   = x_mag[XW-1:YW];
            dq0   = x_mag[YW-1:0];
        end else begin
            sx    = bus.signed_op & bus.x[15];
            sy    = bus.signed_op & bus.y[7];
            x_mag = {16'd0, sx ? x_lo_neg : bus.x[15:0]};
            y_mag = {8'd0, sy ? y_lo_neg : bus.y[7:0]};
            hi0   = {8'd0, x_mag[15:8]};
            dq0   = {x_mag[7:0], 8'd0};
        end
    end

    // The accepting edge already retires the first quotient bit(s).
    assign first_s = iter(hi0, dq0, y_mag);
    assign run_s   = iter(rem_q, dq_q, d_q);

    logic [YW-1:0]  qmag, rmag, quo_s, rem_s;
    logic [YW:0]    lim;
    logic           exc_v;
    logic [XW-1:0]  res;

    // ovf_q is the extra quotient bit: set when the magnitude quotient exceeds the result width.
    always_comb begin
        qmag  = word_q ? dq_q  : {8'd0, dq_q[7:0]};
        rmag  = word_q ? rem_q : {8'd0, rem_q[7:0]};
        quo_s = (sx_q ^ sy_q) ? -qmag : qmag;
        rem_s = sx_q ? -rmag : rmag;
        lim   = word_q ? 17'h07FFF : 17'h0007F;
        if (sx_q ^ sy_q)
            lim = lim + 17'd1;
        exc_v = zero_q | ovf_q | (signed_q & ({1'b0, qmag} > lim));
        res   = word_q ? {rem_s, quo_s} : {16'd0, rem_s[7:0], quo_s[7:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = (y_mag == '0) ? FIX : RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt_q == 4'd1)
                    state_d = FIX;
            end
            FIX: begin
                fix     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q    <= '0;
            dq_q     <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            word_q   <= 1'b0;
            signed_q <= 1'b0;
            sx_q     <= 1'b0;
            sy_q     <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
            exc_q    <= 1'b0;
            out_q    <= '0;
        end else begin
            done_q <= fix;
            if (load) begin
                word_q        <= bus.word_op;
                signed_q      <= bus.signed_op;
                sx_q          <= sx;
                sy_q          <= sy;
                d_q           <= y_mag;
                ovf_q         <= (hi0 >= y_mag);
                zero_q        <= (y_mag == '0);
                {rem_q, dq_q} <= first_s;
                cnt_q         <= bus.word_op ? RUN_W : RUN_B;
            end
            if (step) begin
                {rem_q, dq_q} <= run_s;
                cnt_q         <= cnt_q - 4'd1;
            end
            if (fix) begin
                exc_q <= exc_v;
                if (!exc_v)
                    out_q <= res;
            end
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.exc  = exc_q;
    assign bus.out  = out_q;

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: arithmetic reference model with per-cycle compare plus literal pins.
module tb_div_seq;

`ifdef DIV_RADIX4_EN
    localparam int LW = 9;
    localparam int LB = 5;
`else
    localparam int LW = 17;
    localparam int LB = 9;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_seq_if bus ();
    div_seq dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state
    logic        active = 1'b0;
    int          s_edge = 0;
    int          d_edge = 0;
    logic [31:0] m_res = '0;
    logic        m_exc = 1'b0;
    logic [31:0] exp_out = '0;
    logic        exp_exc = 1'b0;
    int          last_done = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model(input logic [31:0] xv, input logic [15:0] yv,
                                  input logic w, input logic s,
                                  output logic [31:0] res, output logic e, output int lat);
        longint dv, ds, q, r;
        logic [15:0] xb;
        logic [7:0]  yb;
        xb = xv[15:0];
        yb = yv[7:0];
        if (w) begin
            dv = s ? longint'($signed(xv)) : longint'({32'd0, xv});
            ds = s ? longint'($signed(yv)) : longint'({48'd0, yv});
        end else begin
            dv = s ? longint'($signed(xb)) : longint'({48'd0, xb});
            ds = s ? longint'($signed(yb)) : longint'({56'd0, yb});
        end
        res = '0;
        e   = 1'b0;
        lat = 2;
        if (ds == 0) begin
            e = 1'b1;
        end else begin
            q = dv / ds;
            r = dv % ds;
            if (w) begin
                e   = s ? (q < -32768 || q > 32767) : (q > 65535);
                res = {r[15:0], q[15:0]};
                lat = LW;
            end else begin
                e   = s ? (q < -128 || q > 127) : (q > 255);
                res = {16'd0, r[7:0], q[7:0]};
                lat = LB;
            end
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle compare, sampled just after each rising edge
    always @(posedge clk) begin
        logic eb, ed;
        #1;
        eb = active && cyc >= s_edge && cyc < d_edge;
        ed = active && cyc == d_edge;
        if (ed) begin
            exp_exc = m_exc;
            if (!m_exc)
                exp_out = m_res;
        end
        if (bus.done === 1'b1)
            last_done = cyc;
        chk("busy", {31'd0, bus.busy}, {31'd0, eb});
        chk("done", {31'd0, bus.done}, {31'd0, ed});
        chk("exc",  {31'd0, bus.exc},  {31'd0, exp_exc});
        chk("out",  bus.out, exp_out);
        if (ed)
            active = 1'b0;
    end

    // Call at a falling edge; start is seen by the next rising edge.
    task automatic issue(input logic [31:0] xv, input logic [15:0] yv, input logic w, input logic s);
        int lat;
        bus.x         = xv;
        bus.y         = yv;
        bus.word_op   = w;
        bus.signed_op = s;
        bus.start     = 1'b1;
        model(xv, yv, w, s, m_res, m_exc, lat);
        s_edge = cyc + 1;
        d_edge = s_edge + lat - 1;
        active = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && active; i++)
            @(negedge clk);
        checks++;
        if (active) begin
            errors++;
            $display("FAIL timeout: done not seen, expected at cycle %0d", d_edge);
            active = 1'b0;
        end
    endtask

    task automatic op_lit(input logic [31:0] xv, input logic [15:0] yv, input logic w, input logic s,
                          input logic [31:0] lo, input logic le, input int ll, input int gap);
        issue(xv, yv, w, s);
        wait_done();
        chk("lit_out", bus.out, lo);
        chk("lit_exc", {31'd0, bus.exc}, {31'd0, le});
        chk("lit_lat", last_done - s_edge + 1, ll);
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        bus.word_op   = 1'b0;
        bus.signed_op = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_out",  bus.out, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        op_lit(32'h0001_0000, 16'h0003, 1, 0, 32'h0001_5555, 0, LW, 1);
        op_lit(32'h0000_FF9C, 16'h0007, 0, 1, 32'h0000_FEF2, 0, LB, 0);
        op_lit(32'h1234_5678, 16'h0000, 1, 0, 32'h0000_FEF2, 1, 2,  0);
        op_lit(32'h0002_0000, 16'h0001, 1, 0, 32'h0000_FEF2, 1, LW, 2);
        op_lit(32'h0000_00FF, 16'h0001, 0, 0, 32'h0000_00FF, 0, LB, 0);
        op_lit(32'hFFFF_8000, 16'h0001, 1, 1, 32'h0000_8000, 0, LW, 0);
        op_lit(32'hFFFF_8000, 16'hFFFF, 1, 1, 32'h0000_8000, 1, LW, 1);
        op_lit(32'hABCD_0064, 16'hFF07, 0, 0, 32'h0000_020E, 0, LB, 0);
        op_lit(32'hFFF0_BDC0, 16'h03E8, 1, 1, 32'h0000_FC18, 0, LW, 0);
        op_lit(32'h0000_0007, 16'hFFFE, 1, 1, 32'h0001_FFFD, 0, LW, 3);
        op_lit(32'h0000_FF80, 16'h00FF, 0, 1, 32'h0001_FFFD, 1, LB, 0);
        op_lit(32'h0000_FF80, 16'h0001, 0, 1, 32'h0000_0080, 0, LB, 0);
        op_lit(32'hFFFF_FFFF, 16'hFFFF, 1, 0, 32'h0000_0080, 1, LW, 0);
        op_lit(32'hFFFE_FFFF, 16'hFFFF, 1, 0, 32'hFFFE_FFFF, 0, LW, 1);
        op_lit(32'h0000_0064, 16'h00F9, 0, 1, 32'h0000_02F2, 0, LB, 0);
        op_lit(32'h0000_1234, 16'h0100, 0, 0, 32'h0000_02F2, 1, 2,  2);

        // A start pulse mid-operation must be dropped: one done, original result.
        issue(32'h0001_86A0, 16'h0007, 1, 0);
        while (cyc < s_edge + 4) @(negedge clk);
        bus.x     = '0;
        bus.y     = '0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        chk("poke_out", bus.out, 32'h0005_37CD);
        repeat (LW + 4) @(negedge clk);

        // Reset in the middle of a run clears everything at once.
        issue(32'h0001_2345, 16'h0010, 1, 1);
        while (cyc < s_edge + 4) @(negedge clk);
        rst     = 1'b1;
        active  = 1'b0;
        exp_out = '0;
        exp_exc = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
        chk("mid_rst_out",  bus.out, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        op_lit(32'h0001_0000, 16'h0003, 1, 0, 32'h0001_5555, 0, LW, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
